// File: rtl/tlu_handshake_fsm.sv
// TLU front-end controller: synchronises the TLU trigger line, accepts or
// vetoes triggers, and runs the BUSY / trigger-number handshake with the
// downstream serial-to-parallel stage.
//
// state            | meaning
// -----------------+-----------------------------------------------------
// IDLE             | waiting for a synchronised trigger rising edge
// WAIT_TRIGGER_LOW | trigger accepted, waiting for the TLU to drop it
// WAIT_DATA        | trigger-number readout requested, BUSY held high
// RELEASE          | BUSY forced low for one cycle before re-arming
module tlu_handshake_fsm #(
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [1:0]               TLU_MODE,
    input  logic                     TLU_TRIGGER_ASYNC,
    input  logic                     TLU_VETO,
    input  logic [TIMEOUT_WIDTH-1:0] TLU_HANDSHAKE_TIMEOUT,
    input  logic                     TLU_DATA_RECEIVED_FLAG,
    output logic                     TLU_TRIGGER,
    output logic                     TLU_BUSY,
    output logic                     TLU_RECEIVE_DATA_FLAG,
    output logic                     TRIGGER_ACCEPTED_FLAG,
    output logic                     TIMEOUT_ERROR_FLAG,
    output logic [15:0]              TRIGGER_COUNTER,
    output logic [7:0]               LOST_TRIGGER_COUNTER
);

    typedef enum logic [1:0] {
        IDLE             = 2'd0,
        WAIT_TRIGGER_LOW = 2'd1,
        WAIT_DATA        = 2'd2,
        RELEASE          = 2'd3
    } state_t;

    state_t                   state_q;
    state_t                   state_nxt;
    logic [1:0]               mode_q;
    logic [1:0]               mode_nxt;
    logic [TIMEOUT_WIDTH-1:0] cnt_q;
    logic [TIMEOUT_WIDTH-1:0] cnt_nxt;
    logic                     trig_meta;
    logic                     trig_d;
    logic                     trig_rise;
    logic                     timeout_hit;
    logic                     busy_nxt;
    logic                     rx_nxt;
    logic                     acc_nxt;
    logic                     to_nxt;
    logic [15:0]              trig_cnt_nxt;
    logic [7:0]               lost_cnt_nxt;

    // Two-flop synchroniser on the raw trigger plus one delay flop for edge detection
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            trig_meta   <= 1'b0;
            TLU_TRIGGER <= 1'b0;
            trig_d      <= 1'b0;
        end else begin
            trig_meta   <= TLU_TRIGGER_ASYNC;
            TLU_TRIGGER <= trig_meta;
            trig_d      <= TLU_TRIGGER;
        end
    end

    assign trig_rise   = TLU_TRIGGER & ~trig_d;
    assign timeout_hit = (TLU_HANDSHAKE_TIMEOUT != '0) && (cnt_q == TLU_HANDSHAKE_TIMEOUT);

    // Next-state, next-output and counter logic; normal exits take priority over the timeout
    always_comb begin
        state_nxt    = state_q;
        mode_nxt     = mode_q;
        cnt_nxt      = cnt_q;
        busy_nxt     = TLU_BUSY;
        rx_nxt       = 1'b0;
        acc_nxt      = 1'b0;
        to_nxt       = 1'b0;
        trig_cnt_nxt = TRIGGER_COUNTER;
        lost_cnt_nxt = LOST_TRIGGER_COUNTER;
        case (state_q)
            IDLE: begin
                busy_nxt = 1'b0;
                if (trig_rise && (TLU_MODE != 2'd0)) begin
                    if (!TLU_VETO) begin
                        acc_nxt      = 1'b1;
                        trig_cnt_nxt = TRIGGER_COUNTER + 16'd1;
                        mode_nxt     = TLU_MODE;
                        busy_nxt     = TLU_MODE[1];
                        cnt_nxt      = '0;
                        state_nxt    = WAIT_TRIGGER_LOW;
                    end else if (LOST_TRIGGER_COUNTER != 8'hFF) begin
                        lost_cnt_nxt = LOST_TRIGGER_COUNTER + 8'd1;
                    end
                end
            end
            WAIT_TRIGGER_LOW: begin
                cnt_nxt = cnt_q + 1'b1;
                if (!TLU_TRIGGER) begin
                    if (mode_q == 2'd3) begin
                        rx_nxt    = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = WAIT_DATA;
                    end else begin
                        busy_nxt  = 1'b0;
                        state_nxt = RELEASE;
                    end
                end else if (timeout_hit && (mode_q != 2'd1)) begin
                    to_nxt    = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = RELEASE;
                end
            end
            WAIT_DATA: begin
                cnt_nxt = cnt_q + 1'b1;
                if (TLU_DATA_RECEIVED_FLAG) begin
                    busy_nxt  = 1'b0;
                    state_nxt = RELEASE;
                end else if (timeout_hit) begin
                    to_nxt    = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State, latched mode, timeout counter and all registered outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q               <= IDLE;
            mode_q                <= 2'd0;
            cnt_q                 <= '0;
            TLU_BUSY              <= 1'b0;
            TLU_RECEIVE_DATA_FLAG <= 1'b0;
            TRIGGER_ACCEPTED_FLAG <= 1'b0;
            TIMEOUT_ERROR_FLAG    <= 1'b0;
            TRIGGER_COUNTER       <= 16'd0;
            LOST_TRIGGER_COUNTER  <= 8'd0;
        end else begin
            state_q               <= state_nxt;
            mode_q                <= mode_nxt;
            cnt_q                 <= cnt_nxt;
            TLU_BUSY              <= busy_nxt;
            TLU_RECEIVE_DATA_FLAG <= rx_nxt;
            TRIGGER_ACCEPTED_FLAG <= acc_nxt;
            TIMEOUT_ERROR_FLAG    <= to_nxt;
            TRIGGER_COUNTER       <= trig_cnt_nxt;
            LOST_TRIGGER_COUNTER  <= lost_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_tlu_handshake_fsm.sv
// Directed bench for tlu_handshake_fsm; inputs change and outputs are sampled 1 time unit after CLK rises.
module tb_tlu_handshake_fsm;

    logic        CLK;
    logic        RESET_N;
    logic [1:0]  TLU_MODE;
    logic        TLU_TRIGGER_ASYNC;
    logic        TLU_VETO;
    logic [7:0]  TLU_HANDSHAKE_TIMEOUT;
    logic        TLU_DATA_RECEIVED_FLAG;
    logic        TLU_TRIGGER;
    logic        TLU_BUSY;
    logic        TLU_RECEIVE_DATA_FLAG;
    logic        TRIGGER_ACCEPTED_FLAG;
    logic        TIMEOUT_ERROR_FLAG;
    logic [15:0] TRIGGER_COUNTER;
    logic [7:0]  LOST_TRIGGER_COUNTER;

    int          n_checks;
    int          n_pass;
    logic [15:0] exp_cnt;

    tlu_handshake_fsm #(.TIMEOUT_WIDTH(8)) dut (
        .CLK                    (CLK),
        .RESET_N                (RESET_N),
        .TLU_MODE               (TLU_MODE),
        .TLU_TRIGGER_ASYNC      (TLU_TRIGGER_ASYNC),
        .TLU_VETO               (TLU_VETO),
        .TLU_HANDSHAKE_TIMEOUT  (TLU_HANDSHAKE_TIMEOUT),
        .TLU_DATA_RECEIVED_FLAG (TLU_DATA_RECEIVED_FLAG),
        .TLU_TRIGGER            (TLU_TRIGGER),
        .TLU_BUSY               (TLU_BUSY),
        .TLU_RECEIVE_DATA_FLAG  (TLU_RECEIVE_DATA_FLAG),
        .TRIGGER_ACCEPTED_FLAG  (TRIGGER_ACCEPTED_FLAG),
        .TIMEOUT_ERROR_FLAG     (TIMEOUT_ERROR_FLAG),
        .TRIGGER_COUNTER        (TRIGGER_COUNTER),
        .LOST_TRIGGER_COUNTER   (LOST_TRIGGER_COUNTER)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++; if (TLU_BUSY !== 1'b0) $display("FAIL rst_busy: got %b want 0", TLU_BUSY); else n_pass++;
        n_checks++; if (TRIGGER_COUNTER !== 16'd0) $display("FAIL rst_cnt: got %0h want 0", TRIGGER_COUNTER); else n_pass++;
        n_checks++; if (LOST_TRIGGER_COUNTER !== 8'd0) $display("FAIL rst_lost: got %0h want 0", LOST_TRIGGER_COUNTER); else n_pass++;
        n_checks++;
        if ({TLU_TRIGGER, TLU_RECEIVE_DATA_FLAG, TRIGGER_ACCEPTED_FLAG, TIMEOUT_ERROR_FLAG} !== 4'd0)
            $display("FAIL rst_flags: got %b want 0000", {TLU_TRIGGER, TLU_RECEIVE_DATA_FLAG, TRIGGER_ACCEPTED_FLAG, TIMEOUT_ERROR_FLAG});
        else n_pass++;
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic test_mode2();
        TLU_MODE = 2'd2; TLU_HANDSHAKE_TIMEOUT = 8'd0; TLU_VETO = 1'b0;
        tick();
        TLU_TRIGGER_ASYNC = 1'b1;
        tick(); tick();
        n_checks++; if (TLU_TRIGGER !== 1'b1) $display("FAIL m2_sync: got %b want 1", TLU_TRIGGER); else n_pass++;
        n_checks++; if (TLU_BUSY !== 1'b0) $display("FAIL m2_busy_early: got %b want 0", TLU_BUSY); else n_pass++;
        tick();
        exp_cnt = exp_cnt + 16'd1;
        n_checks++; if (TLU_BUSY !== 1'b1) $display("FAIL m2_busy_rise: got %b want 1", TLU_BUSY); else n_pass++;
        n_checks++; if (TRIGGER_ACCEPTED_FLAG !== 1'b1) $display("FAIL m2_acc: got %b want 1", TRIGGER_ACCEPTED_FLAG); else n_pass++;
        n_checks++; if (TRIGGER_COUNTER !== exp_cnt) $display("FAIL m2_cnt: got %0h want %0h", TRIGGER_COUNTER, exp_cnt); else n_pass++;
        tick();
        n_checks++; if (TRIGGER_ACCEPTED_FLAG !== 1'b0) $display("FAIL m2_acc_pulse: got %b want 0", TRIGGER_ACCEPTED_FLAG); else n_pass++;
        repeat (6) tick();
        TLU_TRIGGER_ASYNC = 1'b0;
        tick(); tick();
        n_checks++; if (TLU_TRIGGER !== 1'b0) $display("FAIL m2_sync_low: got %b want 0", TLU_TRIGGER); else n_pass++;
        n_checks++; if (TLU_BUSY !== 1'b1) $display("FAIL m2_busy_hold: got %b want 1", TLU_BUSY); else n_pass++;
        tick();
        n_checks++; if (TLU_BUSY !== 1'b0) $display("FAIL m2_busy_fall: got %b want 0", TLU_BUSY); else n_pass++;
        repeat (3) tick();
    endtask

    task automatic test_mode3_data();
        int rx_cnt, to_cnt, low_cnt;
        rx_cnt = 0; to_cnt = 0; low_cnt = 0;
        TLU_MODE = 2'd3; TLU_HANDSHAKE_TIMEOUT = 8'd0;
        tick();
        TLU_TRIGGER_ASYNC = 1'b1;
        repeat (3) tick();
        exp_cnt = exp_cnt + 16'd1;
        n_checks++; if (TRIGGER_COUNTER !== exp_cnt) $display("FAIL m3_cnt: got %0h want %0h", TRIGGER_COUNTER, exp_cnt); else n_pass++;
        tick();
        TLU_TRIGGER_ASYNC = 1'b0;
        for (int i = 1; i <= 43; i++) begin
            tick();
            if (TLU_RECEIVE_DATA_FLAG) rx_cnt++;
            if (TIMEOUT_ERROR_FLAG) to_cnt++;
            if (!TLU_BUSY) low_cnt++;
            if (i == 3) begin
                n_checks++; if (TLU_RECEIVE_DATA_FLAG !== 1'b1) $display("FAIL m3_rx_timing: got %b want 1", TLU_RECEIVE_DATA_FLAG); else n_pass++;
            end
        end
        TLU_DATA_RECEIVED_FLAG = 1'b1;
        tick();
        TLU_DATA_RECEIVED_FLAG = 1'b0;
        n_checks++; if (TLU_BUSY !== 1'b0) $display("FAIL m3_busy_release: got %b want 0", TLU_BUSY); else n_pass++;
        n_checks++; if (rx_cnt !== 1) $display("FAIL m3_rx_count: got %0d want 1", rx_cnt); else n_pass++;
        n_checks++; if (to_cnt !== 0) $display("FAIL m3_no_timeout: got %0d want 0", to_cnt); else n_pass++;
        n_checks++; if (low_cnt !== 0) $display("FAIL m3_busy_held: busy low %0d cycles, want 0", low_cnt); else n_pass++;
        tick();
        n_checks++; if (TLU_BUSY !== 1'b0) $display("FAIL m3_busy_idle: got %b want 0", TLU_BUSY); else n_pass++;
        repeat (2) tick();
    endtask

    task automatic test_mode3_timeout();
        int to_cnt;
        to_cnt = 0;
        TLU_MODE = 2'd3; TLU_HANDSHAKE_TIMEOUT = 8'd20;
        tick();
        TLU_TRIGGER_ASYNC = 1'b1;
        repeat (4) tick();
        exp_cnt = exp_cnt + 16'd1;
        TLU_TRIGGER_ASYNC = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (TIMEOUT_ERROR_FLAG) to_cnt++;
            if (i == 23) begin
                n_checks++; if (TIMEOUT_ERROR_FLAG !== 1'b0 || TLU_BUSY !== 1'b1)
                    $display("FAIL to_early: got to=%b busy=%b want to=0 busy=1", TIMEOUT_ERROR_FLAG, TLU_BUSY); else n_pass++;
            end
            if (i == 24) begin
                n_checks++; if (TIMEOUT_ERROR_FLAG !== 1'b1) $display("FAIL to_flag: got %b want 1", TIMEOUT_ERROR_FLAG); else n_pass++;
                n_checks++; if (TLU_BUSY !== 1'b0) $display("FAIL to_busy: got %b want 0", TLU_BUSY); else n_pass++;
            end
        end
        n_checks++; if (to_cnt !== 1) $display("FAIL to_pulse_count: got %0d want 1", to_cnt); else n_pass++;
        TLU_MODE = 2'd2;
        TLU_TRIGGER_ASYNC = 1'b1;
        tick(); tick();
        TLU_TRIGGER_ASYNC = 1'b0;
        tick();
        exp_cnt = exp_cnt + 16'd1;
        n_checks++; if (TRIGGER_ACCEPTED_FLAG !== 1'b1 || TLU_BUSY !== 1'b1)
            $display("FAIL to_next_acc: got acc=%b busy=%b want 1/1", TRIGGER_ACCEPTED_FLAG, TLU_BUSY); else n_pass++;
        n_checks++; if (TRIGGER_COUNTER !== exp_cnt) $display("FAIL to_next_cnt: got %0h want %0h", TRIGGER_COUNTER, exp_cnt); else n_pass++;
        repeat (4) tick();
    endtask

    task automatic test_data_vs_timeout();
        TLU_MODE = 2'd3; TLU_HANDSHAKE_TIMEOUT = 8'd20;
        tick();
        TLU_TRIGGER_ASYNC = 1'b1;
        repeat (4) tick();
        exp_cnt = exp_cnt + 16'd1;
        TLU_TRIGGER_ASYNC = 1'b0;
        repeat (23) tick();
        TLU_DATA_RECEIVED_FLAG = 1'b1;
        tick();
        TLU_DATA_RECEIVED_FLAG = 1'b0;
        n_checks++; if (TLU_BUSY !== 1'b0 || TIMEOUT_ERROR_FLAG !== 1'b0)
            $display("FAIL dvt_priority: got busy=%b to=%b want 0/0", TLU_BUSY, TIMEOUT_ERROR_FLAG); else n_pass++;
        tick();
        n_checks++; if (TIMEOUT_ERROR_FLAG !== 1'b0) $display("FAIL dvt_no_late_to: got %b want 0", TIMEOUT_ERROR_FLAG); else n_pass++;
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        TLU_MODE = 2'd3; TLU_HANDSHAKE_TIMEOUT = 8'd0;
        tick();
        TLU_TRIGGER_ASYNC = 1'b1;
        repeat (4) tick();
        exp_cnt = exp_cnt + 16'd1;
        TLU_TRIGGER_ASYNC = 1'b0;
        repeat (5) tick();
        TLU_DATA_RECEIVED_FLAG = 1'b1;
        TLU_TRIGGER_ASYNC = 1'b1;
        tick();
        TLU_DATA_RECEIVED_FLAG = 1'b0;
        n_checks++; if (TLU_BUSY !== 1'b0) $display("FAIL b2b_release: got %b want 0", TLU_BUSY); else n_pass++;
        tick();
        n_checks++; if (TLU_BUSY !== 1'b0 || TRIGGER_ACCEPTED_FLAG !== 1'b0)
            $display("FAIL b2b_gap: got busy=%b acc=%b want 0/0", TLU_BUSY, TRIGGER_ACCEPTED_FLAG); else n_pass++;
        tick();
        exp_cnt = exp_cnt + 16'd1;
        n_checks++; if (TRIGGER_ACCEPTED_FLAG !== 1'b1 || TLU_BUSY !== 1'b1)
            $display("FAIL b2b_accept: got acc=%b busy=%b want 1/1", TRIGGER_ACCEPTED_FLAG, TLU_BUSY); else n_pass++;
        n_checks++; if (TRIGGER_COUNTER !== exp_cnt) $display("FAIL b2b_cnt: got %0h want %0h", TRIGGER_COUNTER, exp_cnt); else n_pass++;
        TLU_TRIGGER_ASYNC = 1'b0;
        repeat (5) tick();
        TLU_DATA_RECEIVED_FLAG = 1'b1;
        tick();
        TLU_DATA_RECEIVED_FLAG = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_veto();
        logic busy_seen, acc_seen;
        busy_seen = 1'b0; acc_seen = 1'b0;
        TLU_MODE = 2'd1; TLU_VETO = 1'b1; TLU_HANDSHAKE_TIMEOUT = 8'd0;
        tick();
        for (int i = 0; i < 300; i++) begin
            TLU_TRIGGER_ASYNC = 1'b1;
            for (int j = 0; j < 4; j++) begin
                if (j == 2) TLU_TRIGGER_ASYNC = 1'b0;
                tick();
                if (TLU_BUSY) busy_seen = 1'b1;
                if (TRIGGER_ACCEPTED_FLAG) acc_seen = 1'b1;
            end
            if (i == 9) begin
                n_checks++; if (LOST_TRIGGER_COUNTER !== 8'd10) $display("FAIL veto_lost10: got %0d want 10", LOST_TRIGGER_COUNTER); else n_pass++;
            end
            if (i == 254) begin
                n_checks++; if (LOST_TRIGGER_COUNTER !== 8'hFF) $display("FAIL veto_lost255: got %0h want ff", LOST_TRIGGER_COUNTER); else n_pass++;
            end
        end
        repeat (4) tick();
        n_checks++; if (LOST_TRIGGER_COUNTER !== 8'hFF) $display("FAIL veto_saturate: got %0h want ff", LOST_TRIGGER_COUNTER); else n_pass++;
        n_checks++; if (TRIGGER_COUNTER !== exp_cnt) $display("FAIL veto_cnt: got %0h want %0h", TRIGGER_COUNTER, exp_cnt); else n_pass++;
        n_checks++; if (busy_seen !== 1'b0 || acc_seen !== 1'b0)
            $display("FAIL veto_no_accept: got busy_seen=%b acc_seen=%b want 0/0", busy_seen, acc_seen); else n_pass++;
        TLU_VETO = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        TLU_MODE = 2'd1; TLU_VETO = 1'b0;
        tick();
        force dut.TRIGGER_COUNTER = 16'hFFFF;
        tick();
        release dut.TRIGGER_COUNTER;
        tick();
        n_checks++; if (TRIGGER_COUNTER !== 16'hFFFF) $display("FAIL wrap_preset: got %0h want ffff", TRIGGER_COUNTER); else n_pass++;
        TLU_TRIGGER_ASYNC = 1'b1;
        tick(); tick();
        TLU_TRIGGER_ASYNC = 1'b0;
        tick();
        exp_cnt = 16'h0000;
        n_checks++; if (TRIGGER_COUNTER !== exp_cnt) $display("FAIL wrap_cnt: got %0h want 0", TRIGGER_COUNTER); else n_pass++;
        n_checks++; if (TRIGGER_ACCEPTED_FLAG !== 1'b1 || TLU_BUSY !== 1'b0)
            $display("FAIL wrap_m1: got acc=%b busy=%b want 1/0", TRIGGER_ACCEPTED_FLAG, TLU_BUSY); else n_pass++;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        TLU_MODE = 2'd3; TLU_HANDSHAKE_TIMEOUT = 8'd0;
        tick();
        TLU_TRIGGER_ASYNC = 1'b1;
        repeat (4) tick();
        TLU_TRIGGER_ASYNC = 1'b0;
        repeat (6) tick();
        n_checks++; if (TLU_BUSY !== 1'b1) $display("FAIL rmid_in_wait: got %b want 1", TLU_BUSY); else n_pass++;
        #2;
        RESET_N = 1'b0;
        #1;
        n_checks++;
        if ({TLU_TRIGGER, TLU_BUSY, TLU_RECEIVE_DATA_FLAG, TRIGGER_ACCEPTED_FLAG, TIMEOUT_ERROR_FLAG,
             TRIGGER_COUNTER, LOST_TRIGGER_COUNTER} !== 29'd0)
            $display("FAIL rmid_async: got busy=%b cnt=%0h lost=%0h want all 0", TLU_BUSY, TRIGGER_COUNTER, LOST_TRIGGER_COUNTER);
        else n_pass++;
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        exp_cnt = 16'd0;
        tick();
        TLU_MODE = 2'd2;
        TLU_TRIGGER_ASYNC = 1'b1;
        tick(); tick();
        TLU_TRIGGER_ASYNC = 1'b0;
        tick();
        exp_cnt = exp_cnt + 16'd1;
        n_checks++; if (TRIGGER_ACCEPTED_FLAG !== 1'b1 || TLU_BUSY !== 1'b1)
            $display("FAIL rmid_fresh: got acc=%b busy=%b want 1/1", TRIGGER_ACCEPTED_FLAG, TLU_BUSY); else n_pass++;
        n_checks++; if (TRIGGER_COUNTER !== exp_cnt) $display("FAIL rmid_cnt: got %0h want %0h", TRIGGER_COUNTER, exp_cnt); else n_pass++;
        repeat (5) tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        exp_cnt = 16'd0;
        RESET_N = 1'b0;
        TLU_MODE = 2'd0;
        TLU_TRIGGER_ASYNC = 1'b0;
        TLU_VETO = 1'b0;
        TLU_HANDSHAKE_TIMEOUT = 8'd0;
        TLU_DATA_RECEIVED_FLAG = 1'b0;
        test_reset();
        test_mode2();
        test_mode3_data();
        test_mode3_timeout();
        test_data_vs_timeout();
        test_back_to_back();
        test_veto();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
